eth_rx_tlp_extract: RTL

Receive-side NetTLP decapsulator. Sits directly downstream of the 10G Ethernet MAC RX AXI-Stream (64-bit, 156.25 MHz) and directly upstream of the PCIe TX request path. It parses the 48-byte Ethernet/IPv4/UDP/NetTLP header, which is exactly 6 beats, and validates it. It forwards only the encapsulated TLP beats with their sequence number and timestamp. Non-matching or truncated frames are silently drained.

---
 rtl/eth_rx_tlp_extract.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/eth_rx_tlp_extract.sv
// NetTLP receive decapsulator: validates the 6-beat Eth/IPv4/UDP/NetTLP header, forwards TLP beats through one output register.
// Latency 1 cycle, 1 beat/cycle; input stalls only while that register is full. Optional drop reporting: ETH_RX_DROP_CAUSE_EN.
module eth_rx_tlp_extract #(
  parameter logic [15:0] UDP_PORT_BASE = 16'h3000,
  parameter logic [15:0] UDP_PORT_MASK = 16'hFFE0,
  parameter int          CNT_WIDTH     = 32
) (
  input  logic                 clk156,
  input  logic                 sys_rst156_n,
  input  logic [31:0]          local_ip,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic [63:0]          s_axis_tdata,
  input  logic [7:0]           s_axis_tkeep,
  input  logic                 s_axis_tlast,
  input  logic                 s_axis_tuser,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic [63:0]          m_axis_tdata,
  output logic [7:0]           m_axis_tkeep,
  output logic                 m_axis_tlast,
  output logic                 m_axis_tuser,
  output logic [15:0]          tlp_seq,
  output logic [31:0]          tlp_tstamp,
  output logic [CNT_WIDTH-1:0] stat_rx_ok,
  output logic [CNT_WIDTH-1:0] stat_rx_drop
`ifdef ETH_RX_DROP_CAUSE_EN
  ,
  output logic [2:0]           drop_cause,
  output logic                 drop_valid
`endif
);

  typedef enum logic [1:0] {ST_HDR, ST_FWD, ST_DROP} state_t;

  state_t      state_q;
  logic [2:0]  idx_q;
  logic        resync_q;
  logic        first_q;
  logic [3:0]  fail_q;
  logic [3:0]  fail_now;
  logic [3:0]  fail_d;
  logic [15:0] seq_sh_q;
  logic [31:0] ts_sh_q;
  logic [7:0]  b [8];
  logic        in_hs;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

`ifdef ETH_RX_DROP_CAUSE_EN
  function automatic logic [2:0] hdr_cause(input logic [3:0] f);
    if (f[0]) return 3'd2;
    if (f[1]) return 3'd3;
    if (f[2]) return 3'd4;
    if (f[3]) return 3'd5;
    return 3'd0;
  endfunction
`endif

  // Header and drop phases never stall the MAC; only a full output register does.
  always_comb begin
    s_axis_tready = 1'b1;
    if (!sys_rst156_n) begin
      s_axis_tready = 1'b0;
    end else if (!resync_q && state_q == ST_FWD) begin
      s_axis_tready = ~m_axis_tvalid | m_axis_tready;
    end
  end

  assign in_hs = s_axis_tvalid & s_axis_tready;

  // fail bits: [0] ethertype/version, [1] protocol, [2] dst IP, [3] UDP port
  always_comb begin
    for (int i = 0; i < 8; i++) b[i] = s_axis_tdata[8*i +: 8];
    fail_now = 4'b0;
    case (idx_q)
      3'd1: fail_now[0] = (b[4] != 8'h08) || (b[5] != 8'h00) || (b[6] != 8'h45);
      3'd2: fail_now[1] = (b[7] != 8'h11);
      3'd3: fail_now[2] = ({b[6], b[7]} != local_ip[31:16]);
      3'd4: begin
        fail_now[2] = ({b[0], b[1]} != local_ip[15:0]);
        fail_now[3] = (({b[4], b[5]} & UDP_PORT_MASK) != UDP_PORT_BASE);
      end
      default: fail_now = 4'b0;
    endcase
    fail_d = ((idx_q == 3'd0) ? 4'b0 : fail_q) | fail_now;
  end

  always_ff @(posedge clk156) begin
    if (!sys_rst156_n) begin
      state_q       <= ST_HDR;
      idx_q         <= 3'd0;
      resync_q      <= 1'b1;
      first_q       <= 1'b0;
      fail_q        <= 4'b0;
      seq_sh_q      <= 16'h0;
      ts_sh_q       <= 32'h0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= 64'h0;
      m_axis_tkeep  <= 8'h0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      tlp_seq       <= 16'h0;
      tlp_tstamp    <= 32'h0;
      stat_rx_ok    <= '0;
      stat_rx_drop  <= '0;
`ifdef ETH_RX_DROP_CAUSE_EN
      drop_cause    <= 3'd0;
      drop_valid    <= 1'b0;
`endif
    end else begin
`ifdef ETH_RX_DROP_CAUSE_EN
      drop_valid <= 1'b0;
`endif
      if (m_axis_tvalid && m_axis_tready) m_axis_tvalid <= 1'b0;
      if (in_hs) begin
        if (resync_q) begin
          // After reset the stream position is unknown: skip to the next frame boundary.
          if (s_axis_tlast) resync_q <= 1'b0;
        end else begin
          case (state_q)
            ST_HDR: begin
              fail_q <= fail_d;
              if (idx_q == 3'd5) begin
                seq_sh_q <= {b[2], b[3]};
                ts_sh_q  <= {b[4], b[5], b[6], b[7]};
              end
              if (s_axis_tlast) begin
                idx_q        <= 3'd0;
                stat_rx_drop <= sat_inc(stat_rx_drop);
`ifdef ETH_RX_DROP_CAUSE_EN
                drop_cause   <= 3'd1;
                drop_valid   <= 1'b1;
`endif
              end else if (idx_q == 3'd5) begin
                idx_q   <= 3'd0;
                first_q <= 1'b1;
                state_q <= (fail_d == 4'b0) ? ST_FWD : ST_DROP;
              end else begin
                idx_q <= idx_q + 3'd1;
              end
            end
            ST_FWD: begin
              m_axis_tvalid <= 1'b1;
              m_axis_tdata  <= s_axis_tdata;
              m_axis_tkeep  <= s_axis_tkeep;
              m_axis_tlast  <= s_axis_tlast;
              m_axis_tuser  <= s_axis_tlast & s_axis_tuser;
              if (first_q) begin
                first_q    <= 1'b0;
                tlp_seq    <= seq_sh_q;
                tlp_tstamp <= ts_sh_q;
              end
              if (s_axis_tlast) begin
                state_q <= ST_HDR;
                if (s_axis_tuser) begin
                  stat_rx_drop <= sat_inc(stat_rx_drop);
`ifdef ETH_RX_DROP_CAUSE_EN
                  drop_cause   <= 3'd6;
                  drop_valid   <= 1'b1;
`endif
                end else begin
                  stat_rx_ok <= sat_inc(stat_rx_ok);
                end
              end
            end
            default: begin
              if (s_axis_tlast) begin
                state_q      <= ST_HDR;
                stat_rx_drop <= sat_inc(stat_rx_drop);
`ifdef ETH_RX_DROP_CAUSE_EN
                drop_cause   <= hdr_cause(fail_q);
                drop_valid   <= 1'b1;
`endif
              end
            end
          endcase
        end
      end
    end
  end

endmodule
